// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART <-> ALU bridge.
// The state encoding is fixed here so that anything observing r_state agrees on its values.
package uart_alu_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;
  localparam int NB_TMO_DEF  = 24;

  localparam logic [2:0] ST_GET_A  = 3'd0;
  localparam logic [2:0] ST_GET_B  = 3'd1;
  localparam logic [2:0] ST_GET_OP = 3'd2;
  localparam logic [2:0] ST_CALC   = 3'd3;
  localparam logic [2:0] ST_SEND   = 3'd4;

  typedef enum logic [2:0] {
    GET_A  = ST_GET_A,
    GET_B  = ST_GET_B,
    GET_OP = ST_GET_OP,
    CALC   = ST_CALC,
    SEND   = ST_SEND
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  // GET_B and GET_OP are the only states where a stalled RX stream counts as a broken frame.
  function automatic logic is_mid_frame(input state_t s);
    return (s == GET_B) || (s == GET_OP);
  endfunction

endpackage

// File: rtl/uart_alu_if_frame_timer.sv
// Inactivity counter for partial frames.
// It saturates at all-ones, which is also its expiry condition.
module frame_timer #(
  parameter int NB_TMO = 24
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_clr,
  output logic o_expired
);

  logic [NB_TMO-1:0] r_count;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_run && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = &r_count;

endmodule

// File: rtl/uart_alu_if.sv
// Collects A, B and opcode bytes from the RX FIFO, drives the ALU, and returns the result.
// Each result byte is pushed to the TX FIFO and shown on the LEDs.
module uart_alu_if
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int NB_TMO  = NB_TMO_DEF
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_rx_empty,
  input  logic [NB_DATA-1:0] i_rx_data,
  output logic               o_rd_uart,
  input  logic               i_tx_full,
  output logic               o_wr_uart,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_led,
  output logic               o_tmo
);

  state_t             r_state;
  logic [NB_DATA-1:0] r_data_a;
  logic [NB_DATA-1:0] r_data_b;
  logic [NB_OP-1:0]   r_op;
  logic [NB_DATA-1:0] r_result;
  logic               r_tmo;

  logic w_pop;
  logic w_push;
  logic w_run;
  logic w_expired;
  logic w_timeout;

  assign w_pop     = ((r_state == GET_A) || is_mid_frame(r_state)) && !i_rx_empty;
  assign w_push    = (r_state == SEND) && !i_tx_full;
  assign w_run     = is_mid_frame(r_state) && i_rx_empty;
  assign w_timeout = w_run && w_expired;

  frame_timer #(
    .NB_TMO(NB_TMO)
  ) u_frame_timer (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_run    (w_run),
    .i_clr    (w_pop || w_timeout),
    .o_expired(w_expired)
  );

  // A timeout drops back to GET_A but leaves the operand registers untouched.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= GET_A;
      r_data_a <= '0;
      r_data_b <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_tmo    <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        GET_A: begin
          if (w_pop) begin
            r_data_a <= i_rx_data;
            r_state  <= GET_B;
          end
        end
        GET_B: begin
          if (w_pop) begin
            r_data_b <= i_rx_data;
            r_state  <= GET_OP;
          end else if (w_timeout) begin
            r_tmo   <= 1'b1;
            r_state <= GET_A;
          end
        end
        GET_OP: begin
          if (w_pop) begin
            r_op    <= i_rx_data[NB_OP-1:0];
            r_state <= CALC;
          end else if (w_timeout) begin
            r_tmo   <= 1'b1;
            r_state <= GET_A;
          end
        end
        CALC: begin
          r_result <= i_alu_result;
          r_state  <= SEND;
        end
        SEND: begin
          if (w_push) begin
            r_state <= GET_A;
          end
        end
        default: r_state <= GET_A;
      endcase
    end
  end

  assign o_rd_uart = w_pop;
  assign o_wr_uart = w_push;
  assign o_tx_data = r_result;
  assign o_led     = r_result;
  assign o_data_a  = r_data_a;
  assign o_data_b  = r_data_b;
  assign o_op      = r_op;
  assign o_tmo     = r_tmo;

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed and random frames through FIFO models and a behavioural ALU.
// Results are predicted from the bytes sent, using plain integer arithmetic.
module tb_uart_alu_if;
  import uart_alu_pkg::*;

  logic       clock;
  logic       i_reset;
  logic       i_rx_empty;
  logic [7:0] i_rx_data;
  logic       o_rd_uart;
  logic       i_tx_full;
  logic       o_wr_uart;
  logic [7:0] o_tx_data;
  logic [7:0] o_data_a;
  logic [7:0] o_data_b;
  logic [5:0] o_op;
  logic [7:0] aluRes;
  logic [7:0] o_led;
  logic       o_tmo;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rxMem [0:255];
  int rxHead = 0;
  int rxTail = 0;
  int popCount = 0;
  int tmoCount = 0;
  int bothCount = 0;
  int cycleCnt = 0;
  int lastPopCycle = 0;
  int txIdx = 0;
  logic [7:0] txq [$];
  int pushCycles [$];

  uart_alu_if #(.NB_DATA(8), .NB_OP(6), .NB_TMO(4)) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_rx_empty  (i_rx_empty),
    .i_rx_data   (i_rx_data),
    .o_rd_uart   (o_rd_uart),
    .i_tx_full   (i_tx_full),
    .o_wr_uart   (o_wr_uart),
    .o_tx_data   (o_tx_data),
    .o_data_a    (o_data_a),
    .o_data_b    (o_data_b),
    .o_op        (o_op),
    .i_alu_result(aluRes),
    .o_led       (o_led),
    .o_tmo       (o_tmo)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign i_rx_empty = (rxHead == rxTail);
  assign i_rx_data  = rxMem[rxHead & 255];

  // Stand-in for the team ALU; unknown opcodes simply pass operand A through.
  always_comb begin
    aluRes = o_data_a;
    case (o_op)
      OP_ADD:  aluRes = o_data_a + o_data_b;
      OP_SUB:  aluRes = o_data_a - o_data_b;
      OP_AND:  aluRes = o_data_a & o_data_b;
      OP_OR:   aluRes = o_data_a | o_data_b;
      OP_XOR:  aluRes = o_data_a ^ o_data_b;
      OP_NOR:  aluRes = ~(o_data_a | o_data_b);
      OP_SRA:  aluRes = $signed(o_data_a) >>> o_data_b;
      OP_SRL:  aluRes = o_data_a >> o_data_b;
      default: aluRes = o_data_a;
    endcase
  end

  // FIFO side effects and event logging, all taken on the active edge.
  always @(posedge clock) begin
    cycleCnt <= cycleCnt + 1;
    if (o_rd_uart) begin
      rxHead       <= rxHead + 1;
      popCount     <= popCount + 1;
      lastPopCycle <= cycleCnt;
    end
    if (o_wr_uart) begin
      txq.push_back(o_tx_data);
      pushCycles.push_back(cycleCnt);
    end
    if (o_tmo) tmoCount <= tmoCount + 1;
    if (o_rd_uart && o_wr_uart) bothCount <= bothCount + 1;
  end

  function automatic int refResult(input int a, input int b, input int opByte);
    int op;
    int sa;
    op = opByte % 64;
    case (op)
      32: return (a + b) % 256;
      34: return (a - b + 256) % 256;
      36: return a & b;
      37: return a | b;
      38: return a ^ b;
      39: return 255 - (a | b);
      2:  return (b >= 8) ? 0 : (a / (1 << b));
      3: begin
        sa = (a >= 128) ? a - 256 : a;
        if (b >= 8) return (sa < 0) ? 255 : 0;
        return (sa >>> b) & 255;
      end
      default: return a;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rxMem[rxTail & 255] = b;
    rxTail = rxTail + 1;
  endtask

  task automatic sendFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(op);
  endtask

  task automatic waitTx(input int n, input string tag);
    int budget = 300;
    while (txq.size() < n && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    checkOutput({tag, " tx count"}, txq.size(), n);
  endtask

  task automatic waitPops(input int n, input string tag);
    int budget = 300;
    while (popCount < n && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    checkOutput({tag, " pop count"}, popCount, n);
  endtask

  task automatic checkNextTx(input string tag, input int expected);
    int observed;
    observed = (txIdx < txq.size()) ? int'(txq[txIdx]) : -1;
    checkOutput(tag, observed, expected);
    txIdx++;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " rd_uart"}, o_rd_uart, 0);
    checkOutput({tag, " wr_uart"}, o_wr_uart, 0);
    checkOutput({tag, " tx_data"}, o_tx_data, 0);
    checkOutput({tag, " data_a"},  o_data_a, 0);
    checkOutput({tag, " data_b"},  o_data_b, 0);
    checkOutput({tag, " op"},      o_op, 0);
    checkOutput({tag, " led"},     o_led, 0);
    checkOutput({tag, " tmo"},     o_tmo, 0);
  endtask

  initial begin
    int p0;
    int t0;
    int n0;
    int a;
    int b;
    int opIdx;
    logic [7:0] opTable [0:7];
    opTable[0] = 8'(OP_ADD); opTable[1] = 8'(OP_SUB);
    opTable[2] = 8'(OP_AND); opTable[3] = 8'(OP_OR);
    opTable[4] = 8'(OP_XOR); opTable[5] = 8'(OP_NOR);
    opTable[6] = 8'(OP_SRA); opTable[7] = 8'(OP_SRL);

    i_reset   = 1'b1;
    i_tx_full = 1'b0;
    repeat (3) @(negedge clock);
    checkResetOutputs("reset");
    i_reset = 1'b0;
    @(negedge clock);

    $display("[TB] frame 34+7");
    p0 = popCount;
    sendFrame(8'd34, 8'd7, 8'h20);
    waitTx(1, "add");
    checkNextTx("add result", 41);
    checkOutput("add pops", popCount - p0, 3);
    checkOutput("add led", o_led, 41);
    checkOutput("add latency", pushCycles[0] - lastPopCycle, 2);
    checkOutput("add data_a", o_data_a, 34);
    checkOutput("add data_b", o_data_b, 7);
    checkOutput("add op", o_op, 6'h20);

    $display("[TB] back-to-back frames");
    sendFrame(8'd34, 8'd7, 8'h22);
    sendFrame(8'd3, 8'd3, 8'h26);
    waitTx(3, "b2b");
    checkNextTx("b2b sub", 27);
    checkNextTx("b2b xor", 0);
    checkOutput("b2b led", o_led, 0);
    checkOutput("b2b spacing", (pushCycles.size() >= 3) ? pushCycles[2] - pushCycles[1] : -1, 5);

    $display("[TB] tx back-pressure");
    i_tx_full = 1'b1;
    p0 = popCount;
    n0 = txq.size();
    sendFrame(8'd10, 8'd5, 8'h24);
    applyStimulus(8'd7);
    repeat (20) @(negedge clock);
    checkOutput("full no push", txq.size(), n0);
    checkOutput("full pops", popCount - p0, 3);
    checkOutput("full wr_uart", o_wr_uart, 0);
    checkOutput("full rd_uart", o_rd_uart, 0);
    i_tx_full = 1'b0;
    waitTx(n0 + 1, "release");
    checkNextTx("release and", 0);
    repeat (3) @(negedge clock);
    checkOutput("release pops", popCount - p0, 4);
    applyStimulus(8'd8);
    applyStimulus(8'h25);
    waitTx(n0 + 2, "or");
    checkNextTx("or result", 15);

    $display("[TB] arithmetic shift");
    sendFrame(8'h80, 8'd1, 8'h03);
    waitTx(txIdx + 1, "sra");
    checkNextTx("sra result", 8'hC0);
    sendFrame(8'h80, 8'd1, 8'hC3);
    waitTx(txIdx + 1, "sra hi");
    checkNextTx("sra upper bits", 8'hC0);
    checkOutput("sra op", o_op, 3);

    $display("[TB] partial frame timeout");
    t0 = tmoCount;
    p0 = popCount;
    applyStimulus(8'd9);
    waitPops(p0 + 1, "tmo");
    repeat (10) @(negedge clock);
    checkOutput("tmo early", tmoCount - t0, 0);
    repeat (15) @(negedge clock);
    checkOutput("tmo pulse", tmoCount - t0, 1);
    checkOutput("tmo keeps a", o_data_a, 9);
    sendFrame(8'd1, 8'd2, 8'h20);
    waitTx(txIdx + 1, "post tmo");
    checkNextTx("post tmo result", 3);

    $display("[TB] reset mid-frame");
    p0 = popCount;
    applyStimulus(8'd5);
    applyStimulus(8'd6);
    waitPops(p0 + 2, "midrst");
    i_reset = 1'b1;
    @(negedge clock);
    checkResetOutputs("midrst");
    i_reset = 1'b0;
    @(negedge clock);
    sendFrame(8'd4, 8'd4, 8'h20);
    waitTx(txIdx + 1, "post rst");
    checkNextTx("post rst result", 8);
    checkOutput("post rst b", o_data_b, 4);

    $display("[TB] random frames");
    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) b = b % 9;
      opIdx = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        i_tx_full = 1'b1;
        sendFrame(8'(a), 8'(b), opTable[opIdx] | 8'($urandom_range(0, 3) << 6));
        repeat ($urandom_range(1, 8)) @(negedge clock);
        i_tx_full = 1'b0;
      end else begin
        sendFrame(8'(a), 8'(b), opTable[opIdx]);
      end
      waitTx(txIdx + 1, "rand");
      checkNextTx("rand result", refResult(a, b, int'(opTable[opIdx])));
    end

    checkOutput("rd/wr overlap", bothCount, 0);
    checkOutput("rx drained", rxTail - rxHead, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
